// File: rtl/tile_board_sampler.sv
// Tile board sampler: watches a raster RGB pixel stream, samples the centre
// pixel of each cell of a 4x4 tile grid, decodes each colour back to its
// 4-bit tile code and publishes the 64-bit board at end of frame.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   pix_valid    pixel present this cycle (no backpressure)
//   pix_sof      first pixel of frame, qualified by pix_valid
//   pix_data     24-bit RGB pixel, R in [23:16]
//   board_out    cell (r,c) code at [4*(4r+c) +: 4]; held between frames
//   frame_done   1-cycle pulse when board_out has just been updated
//   frame_err    valid with frame_done: unknown colour or unsampled cell
//   frame_abort  1-cycle pulse when a frame restarts before completion
//   busy         high while capturing or publishing
module tile_board_sampler #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned GRID_X0  = 120,
  parameter int unsigned GRID_Y0  = 40,
  parameter int unsigned CELL     = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [23:0] pix_data,
  output logic [63:0] board_out,
  output logic        frame_done,
  output logic        frame_err,
  output logic        frame_abort,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StCapture, StPublish} state_e;

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        sof_acc, accept, last_px;
  logic [9:0]  px_x, px_y;
  logic        col_hit, row_hit;
  logic [1:0]  col_idx, row_idx;

  // Decode stage
  logic        dec_valid_q;
  logic [3:0]  dec_idx_q;
  logic [3:0]  dec_code_q;
  logic        dec_bad_q;

  // Shadow board, per-cell written mask and sticky error
  logic [63:0] shadow_q, shadow_wr;
  logic [15:0] seen_q, seen_wr;
  logic        err_q, err_wr;

  logic [63:0] board_q;
  logic        done_q, ferr_q, abort_q, busy_q;

  function automatic logic [4:0] decode_rgb(input logic [23:0] rgb);
    logic [4:0] r;
    unique case (rgb)
      24'hC0C0C0: r = 5'h00;
      24'hFF99CC: r = 5'h01;
      24'hCC99FF: r = 5'h02;
      24'h9999FF: r = 5'h03;
      24'h99CCFF: r = 5'h04;
      24'h99FFFF: r = 5'h05;
      24'h99FFCC: r = 5'h06;
      24'h99FF99: r = 5'h07;
      24'hCCFF99: r = 5'h08;
      24'hFFFF99: r = 5'h09;
      24'hFFCCFF: r = 5'h0A;
      24'hFF9999: r = 5'h0B;
      24'hE0E0E0: r = 5'h0C;
      default:    r = 5'h1F;  // {bad, 4'hF}
    endcase
    return r;
  endfunction

  // The sof pixel is (0,0) regardless of where the counters stand.
  always_comb begin
    sof_acc = pix_valid & pix_sof;
    accept  = pix_valid & (pix_sof | (state_q == StCapture));
    px_x    = pix_sof ? 10'd0 : x_q;
    px_y    = pix_sof ? 10'd0 : y_q;
    last_px = (px_x == 10'(H_ACTIVE - 1)) && (px_y == 10'(V_ACTIVE - 1));
  end

  always_comb begin
    col_hit = 1'b0;
    col_idx = 2'd0;
    row_hit = 1'b0;
    row_idx = 2'd0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (32'(px_x) == GRID_X0 + c * CELL + CELL / 2) begin
        col_hit = 1'b1;
        col_idx = 2'(c);
      end
    end
    for (int unsigned r = 0; r < 4; r++) begin
      if (32'(px_y) == GRID_Y0 + r * CELL + CELL / 2) begin
        row_hit = 1'b1;
        row_idx = 2'(r);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (accept) begin
      if (px_x == 10'(H_ACTIVE - 1)) begin
        x_d = 10'd0;
        y_d = px_y + 10'd1;
      end else begin
        x_d = px_x + 10'd1;
        y_d = px_y;
      end
      state_d = last_px ? StPublish : StCapture;
    end else if (state_q == StPublish) begin
      state_d = StIdle;
    end
  end

  // Shadow contents including the sample landing this cycle; publish reads
  // this so the final sample of the frame is never lost.
  always_comb begin
    shadow_wr = shadow_q;
    seen_wr   = seen_q;
    err_wr    = err_q;
    if (dec_valid_q) begin
      shadow_wr[{dec_idx_q, 2'b00} +: 4] = dec_code_q;
      seen_wr[dec_idx_q]                 = 1'b1;
      err_wr                             = err_q | dec_bad_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      dec_valid_q <= 1'b0;
      dec_idx_q   <= '0;
      dec_code_q  <= '0;
      dec_bad_q   <= 1'b0;
      shadow_q    <= '1;
      seen_q      <= '0;
      err_q       <= 1'b0;
      board_q     <= '0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dec_valid_q <= accept & row_hit & col_hit;
      dec_idx_q   <= {row_idx, col_idx};
      {dec_bad_q, dec_code_q} <= decode_rgb(pix_data);
      // A new frame wins over any in-flight sample of the old one.
      if (sof_acc) begin
        shadow_q <= '1;
        seen_q   <= '0;
        err_q    <= 1'b0;
      end else begin
        shadow_q <= shadow_wr;
        seen_q   <= seen_wr;
        err_q    <= err_wr;
      end
      done_q  <= (state_q == StPublish);
      if (state_q == StPublish) begin
        board_q <= shadow_wr;
        ferr_q  <= err_wr | ~&seen_wr;
      end
      abort_q <= sof_acc & (state_q == StCapture);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign board_out   = board_q;
  assign frame_done  = done_q;
  assign frame_err   = ferr_q;
  assign frame_abort = abort_q;
  assign busy        = busy_q;

endmodule
